// File: rtl/envelope_generator.sv
// ADSR envelope generator with a two-stage sample scaling pipeline.
// Define ENVELOPE_LEGATO_EN to re-trigger from RELEASE at the current level instead of from zero.
module envelope_generator #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int LEVEL_WIDTH  = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    gate_in,
  input  logic                    env_tick_in,
  input  logic [LEVEL_WIDTH-1:0]  attack_step_in,
  input  logic [LEVEL_WIDTH-1:0]  decay_step_in,
  input  logic [LEVEL_WIDTH-1:0]  sustain_level_in,
  input  logic [LEVEL_WIDTH-1:0]  release_step_in,
  input  logic                    sample_valid_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic                    sample_valid_out,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic [LEVEL_WIDTH-1:0]  env_level_out,
  output logic [2:0]              env_state_out,
  output logic                    active_out
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  localparam logic [LEVEL_WIDTH-1:0] FULL_SCALE = '1;
  localparam int PROD_WIDTH = SAMPLE_WIDTH + LEVEL_WIDTH + 1;

  env_state_t             state;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   gate_q;
  logic                   gate_seen;
  logic                   gate_rise;

  logic [LEVEL_WIDTH:0]   attack_sum;
  logic                   attack_sat;
  logic [LEVEL_WIDTH:0]   decay_diff;
  logic                   decay_hit;
  logic                   release_hit;

  // gate_seen masks the first cycle after reset so a gate held high across reset is not an edge
  assign gate_rise   = gate_seen & gate_in & ~gate_q;

  assign attack_sum  = {1'b0, level} + {1'b0, attack_step_in};
  assign attack_sat  = attack_sum[LEVEL_WIDTH] | (attack_sum[LEVEL_WIDTH-1:0] == FULL_SCALE);
  assign decay_diff  = {1'b0, level} - {1'b0, decay_step_in};
  assign decay_hit   = decay_diff[LEVEL_WIDTH] | (decay_diff[LEVEL_WIDTH-1:0] <= sustain_level_in);
  assign release_hit = (level <= release_step_in);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= ST_IDLE;
      level     <= '0;
      gate_q    <= 1'b0;
      gate_seen <= 1'b0;
    end else begin
      gate_q    <= gate_in;
      gate_seen <= 1'b1;
      case (state)
        ST_IDLE: begin
          level <= '0;
          if (gate_rise) state <= ST_ATTACK;
        end
        ST_ATTACK: begin
          if (!gate_in) begin
            state <= ST_RELEASE;
          end else if (env_tick_in) begin
            if (attack_sat) begin
              level <= FULL_SCALE;
              state <= ST_DECAY;
            end else begin
              level <= attack_sum[LEVEL_WIDTH-1:0];
            end
          end
        end
        ST_DECAY: begin
          if (!gate_in) begin
            state <= ST_RELEASE;
          end else if (env_tick_in) begin
            if (decay_hit) begin
              level <= sustain_level_in;
              state <= ST_SUSTAIN;
            end else begin
              level <= decay_diff[LEVEL_WIDTH-1:0];
            end
          end
        end
        ST_SUSTAIN: begin
          if (!gate_in) state <= ST_RELEASE;
          else          level <= sustain_level_in;
        end
        ST_RELEASE: begin
          if (gate_rise) begin
            state <= ST_ATTACK;
`ifdef ENVELOPE_LEGATO_EN
            level <= level;
`else
            level <= '0;
`endif
          end else if (env_tick_in) begin
            if (release_hit) begin
              level <= '0;
              state <= ST_IDLE;
            end else begin
              level <= level - release_step_in;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          level <= '0;
        end
      endcase
    end
  end

  assign env_level_out = level;
  assign env_state_out = state;
  assign active_out    = (state != ST_IDLE);

  logic signed [PROD_WIDTH-1:0] sample_ext;
  logic signed [PROD_WIDTH-1:0] level_ext;
  logic signed [PROD_WIDTH-1:0] product;
  logic signed [PROD_WIDTH-1:0] product_q;
  logic                         stage1_valid;
  logic                         product_unused;

  // The product of a signed sample and a zero-extended level always fits in PROD_WIDTH bits
  assign sample_ext = {{(LEVEL_WIDTH + 1){sample_in[SAMPLE_WIDTH-1]}}, sample_in};
  assign level_ext  = {{SAMPLE_WIDTH{1'b0}}, 1'b0, level};
  assign product    = sample_ext * level_ext;

  assign product_unused = ^{product_q[PROD_WIDTH-1], product_q[LEVEL_WIDTH-1:0]};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stage1_valid     <= 1'b0;
      product_q        <= '0;
      sample_valid_out <= 1'b0;
      sample_out       <= '0;
    end else begin
      stage1_valid     <= sample_valid_in;
      if (sample_valid_in) product_q <= product;
      sample_valid_out <= stage1_valid;
      if (stage1_valid) sample_out <= product_q[LEVEL_WIDTH +: SAMPLE_WIDTH];
    end
  end

endmodule
